instr_fetch_ctrl: RTL



---
 rtl/bitty_pkg.sv | 39 +++
 rtl/fetch_timeout_ctr.sv | 50 +++++
 rtl/instr_fetch_ctrl.sv | 253 +++++++++++++++++++++++++
 3 files changed

// File: rtl/bitty_pkg.sv
// -----------------------------------------------------------------------------
// bitty_pkg
// Shared definitions for the instruction fetch path:
//   - BYTE_W        : width of one UART byte
//   - FETCH_CMD_DEF : default command byte sent ahead of the PC address byte
//   - fetch_state_e : fetch controller state encoding
//   - cnt_width()   : number of bits needed to hold a counter value 0..max_val
// -----------------------------------------------------------------------------
package bitty_pkg;

  localparam int BYTE_W = 8;

  localparam logic [BYTE_W-1:0] FETCH_CMD_DEF = 8'h03;

  typedef enum logic [3:0] {
    ST_IDLE      = 4'd0,
    ST_SEND_CMD  = 4'd1,
    ST_WAIT_CMD  = 4'd2,
    ST_SEND_ADDR = 4'd3,
    ST_WAIT_ADDR = 4'd4,
    ST_WAIT_HI   = 4'd5,
    ST_WAIT_LO   = 4'd6,
    ST_DONE      = 4'd7,
    ST_ERROR     = 4'd8
  } fetch_state_e;

  // Width of a counter that must represent every value in 0..max_val.
  // Never narrower than one bit so degenerate parameters still elaborate.
  function automatic int cnt_width(input int max_val);
    int w;
    if (max_val < 2) begin
      w = 1;
    end else begin
      w = $clog2(max_val + 1);
    end
    return w;
  endfunction

endpackage

// File: rtl/fetch_timeout_ctr.sv
// -----------------------------------------------------------------------------
// fetch_timeout_ctr
// Loadable down-counter used to time out host replies.
// The counter stops at zero; o_expired is high whenever it reads zero.
// Ports:
//   clk        : system clock, rising edge
//   reset      : synchronous, active-low reset (counter -> 0)
//   i_clr      : force the counter to zero (highest priority after reset)
//   i_load     : load i_load_val
//   i_load_val : reload value (cycles remaining minus one)
//   i_en       : decrement by one while non-zero
//   o_expired  : counter is at zero
// -----------------------------------------------------------------------------
module fetch_timeout_ctr
  import bitty_pkg::*;
#(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_clr,
  input  logic             i_load,
  input  logic [CNT_W-1:0] i_load_val,
  input  logic             i_en,
  output logic             o_expired
);

  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  logic [CNT_W-1:0] r_cnt;

  // Counter register: clear beats load, load beats decrement, hold otherwise.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_cnt <= CNT_ZERO;
    end else if (i_clr) begin
      r_cnt <= CNT_ZERO;
    end else if (i_load) begin
      r_cnt <= i_load_val;
    end else if (i_en && (r_cnt != CNT_ZERO)) begin
      r_cnt <= r_cnt - CNT_ONE;
    end else begin
      r_cnt <= r_cnt;
    end
  end

  assign o_expired = (r_cnt == CNT_ZERO);

endmodule

// File: rtl/instr_fetch_ctrl.sv
// -----------------------------------------------------------------------------
// instr_fetch_ctrl
// Fetches one 16-bit instruction from the host over the shared UART:
// sends a command byte and the PC address byte, then receives the
// instruction high and low bytes. Retries on reply timeout, freezes while
// the core owns the UART, and raises a sticky error when retries run out.
// Ports:
//   clk             : system clock, rising edge
//   reset           : synchronous, active-low reset
//   start           : level; begin a fetch when idle/error and not stopped
//   stop_for_rw     : core owns the UART; hold all fetch activity
//   address         : current PC, low byte sampled when a fetch starts
//   rx_do / rx_data : one-cycle received-byte strobe and its byte
//   tx_done         : one-cycle pulse, UART finished sending a byte
//   tx_start_out    : one-cycle request to send tx_data_out
//   tx_data_out     : byte to send, held until the next send request
//   instruction_out : last completed instruction
//   done_out        : one-cycle pulse when instruction_out updates
//   busy            : high outside IDLE and ERROR
//   err             : sticky retry-exhausted flag
// -----------------------------------------------------------------------------
module instr_fetch_ctrl
  import bitty_pkg::*;
#(
  parameter int              ADDR_W         = 8,
  parameter int              INSTR_W        = 16,
  parameter logic [7:0]      FETCH_CMD      = FETCH_CMD_DEF,
  parameter int              TIMEOUT_CYCLES = 1_000_000,
  parameter int              MAX_RETRY      = 3
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic               stop_for_rw,
  input  logic [ADDR_W-1:0]  address,
  input  logic               rx_do,
  input  logic [BYTE_W-1:0]  rx_data,
  input  logic               tx_done,
  output logic               tx_start_out,
  output logic [BYTE_W-1:0]  tx_data_out,
  output logic [INSTR_W-1:0] instruction_out,
  output logic               done_out,
  output logic               busy,
  output logic               err
);

  localparam int TMO_W   = cnt_width(TIMEOUT_CYCLES - 1);
  localparam int RETRY_W = cnt_width(MAX_RETRY);

  // The down-counter is reloaded with TIMEOUT_CYCLES-1 and expires at zero,
  // so expiry lands on the TIMEOUT_CYCLES-th waiting cycle.
  localparam logic [TMO_W-1:0]   TMO_RELOAD  = TMO_W'(TIMEOUT_CYCLES - 1);
  localparam logic [RETRY_W-1:0] RETRY_LIMIT = RETRY_W'(MAX_RETRY);
  localparam logic [RETRY_W-1:0] RETRY_ZERO  = {RETRY_W{1'b0}};
  localparam logic [RETRY_W-1:0] RETRY_ONE   = RETRY_W'(1);

  // State and data registers
  fetch_state_e        r_state;
  logic [BYTE_W-1:0]   r_addr_byte;
  logic [BYTE_W-1:0]   r_hi;
  logic [RETRY_W-1:0]  r_retry;

  // Output registers
  logic                r_tx_start;
  logic [BYTE_W-1:0]   r_tx_data;
  logic [INSTR_W-1:0]  r_instr;
  logic                r_done;
  logic                r_busy;
  logic                r_err;

  // Next-state decode
  fetch_state_e        w_next;
  logic                w_accept_start;
  logic                w_send_pulse;
  logic [BYTE_W-1:0]   w_send_byte;
  logic                w_hi_capture;
  logic                w_lo_capture;
  logic                w_retry_inc;
  logic                w_tmo_clr;
  logic                w_tmo_load;
  logic                w_tmo_en;
  logic                w_tmo_expired;
  logic                w_retry_left;

  assign w_retry_left = (r_retry < RETRY_LIMIT);

  fetch_timeout_ctr #(
    .CNT_W (TMO_W)
  ) u_tmo (
    .clk        (clk),
    .reset      (reset),
    .i_clr      (w_tmo_clr),
    .i_load     (w_tmo_load),
    .i_load_val (TMO_RELOAD),
    .i_en       (w_tmo_en),
    .o_expired  (w_tmo_expired)
  );

  // Next-state and control decode; stop_for_rw freezes everything, so
  // strobes from the UART and start are simply not looked at while it is high.
  always_comb begin
    w_next         = r_state;
    w_accept_start = 1'b0;
    w_send_pulse   = 1'b0;
    w_send_byte    = r_tx_data;
    w_hi_capture   = 1'b0;
    w_lo_capture   = 1'b0;
    w_retry_inc    = 1'b0;
    w_tmo_clr      = 1'b0;
    w_tmo_load     = 1'b0;
    w_tmo_en       = 1'b0;
    if (stop_for_rw) begin
      w_next = r_state;
    end else begin
      case (r_state)
        ST_IDLE, ST_ERROR: begin
          w_tmo_clr = 1'b1;
          if (start) begin
            w_accept_start = 1'b1;
            w_next         = ST_SEND_CMD;
          end else begin
            w_next = r_state;
          end
        end
        ST_SEND_CMD: begin
          w_send_pulse = 1'b1;
          w_send_byte  = FETCH_CMD;
          w_tmo_load   = 1'b1;
          w_next       = ST_WAIT_CMD;
        end
        ST_WAIT_CMD: begin
          w_tmo_load = 1'b1;
          if (tx_done) begin
            w_next = ST_SEND_ADDR;
          end else begin
            w_next = ST_WAIT_CMD;
          end
        end
        ST_SEND_ADDR: begin
          w_send_pulse = 1'b1;
          w_send_byte  = r_addr_byte;
          w_tmo_load   = 1'b1;
          w_next       = ST_WAIT_ADDR;
        end
        ST_WAIT_ADDR: begin
          // Keeps the reload value in place so WAIT_HI starts with a full window.
          w_tmo_load = 1'b1;
          if (tx_done) begin
            w_next = ST_WAIT_HI;
          end else begin
            w_next = ST_WAIT_ADDR;
          end
        end
        ST_WAIT_HI, ST_WAIT_LO: begin
          // A byte arriving on the expiry cycle is accepted: rx is checked first.
          if (rx_do) begin
            w_tmo_load = 1'b1;
            if (r_state == ST_WAIT_HI) begin
              w_hi_capture = 1'b1;
              w_next       = ST_WAIT_LO;
            end else begin
              w_lo_capture = 1'b1;
              w_next       = ST_DONE;
            end
          end else if (w_tmo_expired) begin
            if (w_retry_left) begin
              w_retry_inc = 1'b1;
              w_next      = ST_SEND_CMD;
            end else begin
              w_next = ST_ERROR;
            end
          end else begin
            w_tmo_en = 1'b1;
            w_next   = r_state;
          end
        end
        ST_DONE: begin
          w_tmo_clr = 1'b1;
          w_next    = ST_IDLE;
        end
        default: begin
          w_next = ST_IDLE;
        end
      endcase
    end
  end

  // State register plus per-fetch bookkeeping (address byte, high byte, retries).
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state     <= ST_IDLE;
      r_addr_byte <= {BYTE_W{1'b0}};
      r_hi        <= {BYTE_W{1'b0}};
      r_retry     <= RETRY_ZERO;
    end else begin
      r_state <= w_next;
      if (w_accept_start) begin
        r_addr_byte <= address[BYTE_W-1:0];
      end else begin
        r_addr_byte <= r_addr_byte;
      end
      if (w_hi_capture) begin
        r_hi <= rx_data;
      end else begin
        r_hi <= r_hi;
      end
      if (w_accept_start) begin
        r_retry <= RETRY_ZERO;
      end else if (w_retry_inc) begin
        r_retry <= r_retry + RETRY_ONE;
      end else begin
        r_retry <= r_retry;
      end
    end
  end

  // Output registers: all outputs are flops derived from the decoded transition.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_tx_start <= 1'b0;
      r_tx_data  <= {BYTE_W{1'b0}};
      r_instr    <= {INSTR_W{1'b0}};
      r_done     <= 1'b0;
      r_busy     <= 1'b0;
      r_err      <= 1'b0;
    end else begin
      r_tx_start <= w_send_pulse;
      r_tx_data  <= w_send_byte;
      r_done     <= w_lo_capture;
      r_busy     <= (w_next != ST_IDLE) && (w_next != ST_ERROR);
      if (w_lo_capture) begin
        r_instr <= INSTR_W'({r_hi, rx_data});
      end else begin
        r_instr <= r_instr;
      end
      if (w_accept_start) begin
        r_err <= 1'b0;
      end else if (w_next == ST_ERROR) begin
        r_err <= 1'b1;
      end else begin
        r_err <= r_err;
      end
    end
  end

  assign tx_start_out    = r_tx_start;
  assign tx_data_out     = r_tx_data;
  assign instruction_out = r_instr;
  assign done_out        = r_done;
  assign busy            = r_busy;
  assign err             = r_err;

endmodule
